conv_window_gen: RTL and testbench

//  Streaming 3x3 window generator for the Sobel/convolution path. Accepts raster grey pixels one per

---
 rtl/conv_window_gen_pkg.sv | 19 +
 rtl/conv_window_gen_line_ram.sv | 20 ++
 rtl/conv_window_gen.sv | 196 +++++++++++++++++++
 tb/tb_conv_window_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/conv_window_gen_pkg.sv
// conv_window_gen_pkg: default geometry, FSM state encoding, window slot indices and rotation helper
package conv_window_gen_pkg;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int PIX_W_DEF = 8;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_STREAM, S_EOL, S_FLUSH} state_t;
  localparam int T0 = 8;
  localparam int T1 = 7;
  localparam int T2 = 6;
  localparam int M0 = 5;
  localparam int M1 = 4;
  localparam int M2 = 3;
  localparam int B0 = 2;
  localparam int B1 = 1;
  localparam int B2 = 0;
  function automatic logic [1:0] rot_inc(input logic [1:0] r);
    return r == 2'd2 ? 2'd0 : r + 2'd1;
  endfunction
endpackage

// File: rtl/conv_window_gen_line_ram.sv
// conv_window_gen_line_ram: DEPTH x W simple dual-port RAM, sync write, registered read with enable
module conv_window_gen_line_ram #(
  parameter int DEPTH = 640,
  parameter int W = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming zero-padded 3x3 window generator (pix_* raster in, win_* windows out)
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_sof,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [9*PIX_W-1:0] win,
  output logic               win_valid,
  input  logic               win_ready,
  output logic               win_sof,
  output logic               win_eol,
  output logic               win_eof
);
  localparam int CW = $clog2(IMG_W + 2);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = $clog2(IMG_W);
  localparam logic [CW-1:0] COL_ONE = CW'(1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_PAD = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_ONE = RW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0] rot_q, rot_d;
  logic s1_valid_q, s1_valid_d, s1_emit_q, s1_emit_d, s1_sof_q, s1_sof_d;
  logic s1_eol_q, s1_eol_d, s1_eof_q, s1_eof_d, s1_ztop_q, s1_ztop_d, s1_zmid_q, s1_zmid_d;
  logic [PIX_W-1:0] s1_bot_q, s1_bot_d;
  logic [1:0] s1_tsel_q, s1_tsel_d, s1_msel_q, s1_msel_d;
  logic [8:0][PIX_W-1:0] w_q, w_d;
  logic win_valid_q, win_valid_d, win_sof_q, win_sof_d, win_eol_q, win_eol_d, win_eof_q, win_eof_d;
  logic [2:0] we;
  logic [AW-1:0] waddr, raddr;
  logic [2:0][PIX_W-1:0] rd;
  logic [PIX_W-1:0] top_v, mid_v;
  logic adv, take, start, stream_step, eol_step, flush_step, issue;
  for (genvar i = 0; i < 3; i++) begin : g_ram
    conv_window_gen_line_ram #(.DEPTH(IMG_W), .W(PIX_W)) u_ram (
      .clk(clk), .we(we[i]), .waddr(waddr), .wdata(pix_in),
      .re(adv), .raddr(raddr), .rdata(rd[i])
    );
  end
  assign adv = !win_valid_q || win_ready;
  assign pix_ready = !rst && adv && (state_q == S_IDLE || state_q == S_FILL || state_q == S_STREAM);
  assign take = pix_valid && pix_ready;
  assign start = take && pix_sof;
  assign stream_step = state_q == S_STREAM && take && !pix_sof;
  assign eol_step = state_q == S_EOL && adv;
  assign flush_step = state_q == S_FLUSH && adv && col_q <= COL_PAD;
  assign issue = stream_step || eol_step || flush_step;
  assign top_v = s1_ztop_q ? '0 : rd[s1_tsel_q];
  assign mid_v = s1_zmid_q ? '0 : rd[s1_msel_q];
  assign win = w_q;
  assign win_valid = win_valid_q;
  assign win_sof = win_sof_q;
  assign win_eol = win_eol_q;
  assign win_eof = win_eof_q;
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    rot_d = rot_q;
    we = '0;
    waddr = col_q[AW-1:0];
    raddr = col_q < COL_PAD ? col_q[AW-1:0] : '0;
    s1_valid_d = adv ? 1'b0 : s1_valid_q;
    s1_emit_d = s1_emit_q;
    s1_sof_d = s1_sof_q;
    s1_eol_d = s1_eol_q;
    s1_eof_d = s1_eof_q;
    s1_ztop_d = s1_ztop_q;
    s1_zmid_d = s1_zmid_q;
    s1_bot_d = s1_bot_q;
    s1_tsel_d = s1_tsel_q;
    s1_msel_d = s1_msel_q;
    w_d = w_q;
    win_valid_d = win_valid_q;
    win_sof_d = win_sof_q;
    win_eol_d = win_eol_q;
    win_eof_d = win_eof_q;
    if (adv) begin
      win_valid_d = s1_valid_q && s1_emit_q;
      win_sof_d = s1_valid_q && s1_emit_q && s1_sof_q;
      win_eol_d = s1_valid_q && s1_emit_q && s1_eol_q;
      win_eof_d = s1_valid_q && s1_emit_q && s1_eof_q;
      if (s1_valid_q) begin
        w_d[T0] = w_q[T1];
        w_d[T1] = w_q[T2];
        w_d[T2] = top_v;
        w_d[M0] = w_q[M1];
        w_d[M1] = w_q[M2];
        w_d[M2] = mid_v;
        w_d[B0] = w_q[B1];
        w_d[B1] = w_q[B2];
        w_d[B2] = s1_bot_q;
      end
    end
    // the EOL zero column doubles as the col -1 padding of the next line
    if (issue) begin
      s1_valid_d = 1'b1;
      s1_emit_d = eol_step || col_q != '0;
      s1_sof_d = stream_step && row_q == ROW_ONE && col_q == COL_ONE;
      s1_eol_d = eol_step || (flush_step && col_q == COL_PAD);
      s1_eof_d = flush_step && col_q == COL_PAD;
      s1_ztop_d = eol_step || (stream_step && row_q == ROW_ONE) || col_q == COL_PAD;
      s1_zmid_d = eol_step || col_q == COL_PAD;
      s1_bot_d = stream_step ? pix_in : '0;
      s1_tsel_d = rot_inc(rot_q);
      s1_msel_d = rot_inc(rot_inc(rot_q));
    end
    if (start) begin
      state_d = S_FILL;
      col_d = COL_ONE;
      row_d = '0;
      rot_d = '0;
      we = 3'b001;
      waddr = '0;
      s1_valid_d = 1'b0;
      win_valid_d = 1'b0;
      win_sof_d = 1'b0;
      win_eol_d = 1'b0;
      win_eof_d = 1'b0;
      w_d = '0;
    end else if (state_q == S_FILL && take) begin
      we[rot_q] = 1'b1;
      col_d = col_q == COL_LAST ? '0 : col_q + 1'b1;
      state_d = col_q == COL_LAST ? S_STREAM : S_FILL;
      row_d = col_q == COL_LAST ? ROW_ONE : row_q;
      rot_d = col_q == COL_LAST ? 2'd1 : rot_q;
    end else if (stream_step) begin
      we[rot_q] = 1'b1;
      col_d = col_q == COL_LAST ? '0 : col_q + 1'b1;
      state_d = col_q == COL_LAST ? S_EOL : S_STREAM;
    end else if (eol_step) begin
      // advancing rot into FLUSH keeps the top/mid select formulas valid there
      rot_d = rot_inc(rot_q);
      row_d = row_q == ROW_LAST ? '0 : row_q + 1'b1;
      state_d = row_q == ROW_LAST ? S_FLUSH : S_STREAM;
    end else if (state_q == S_FLUSH) begin
      col_d = flush_step ? col_q + 1'b1 : col_q;
      state_d = win_valid_q && win_ready && win_eof_q ? S_IDLE : S_FLUSH;
      col_d = win_valid_q && win_ready && win_eof_q ? '0 : col_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q <= '0;
      row_q <= '0;
      rot_q <= '0;
      s1_valid_q <= 1'b0;
      s1_emit_q <= 1'b0;
      s1_sof_q <= 1'b0;
      s1_eol_q <= 1'b0;
      s1_eof_q <= 1'b0;
      s1_ztop_q <= 1'b0;
      s1_zmid_q <= 1'b0;
      s1_bot_q <= '0;
      s1_tsel_q <= '0;
      s1_msel_q <= '0;
      w_q <= '0;
      win_valid_q <= 1'b0;
      win_sof_q <= 1'b0;
      win_eol_q <= 1'b0;
      win_eof_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      rot_q <= rot_d;
      s1_valid_q <= s1_valid_d;
      s1_emit_q <= s1_emit_d;
      s1_sof_q <= s1_sof_d;
      s1_eol_q <= s1_eol_d;
      s1_eof_q <= s1_eof_d;
      s1_ztop_q <= s1_ztop_d;
      s1_zmid_q <= s1_zmid_d;
      s1_bot_q <= s1_bot_d;
      s1_tsel_q <= s1_tsel_d;
      s1_msel_q <= s1_msel_d;
      w_q <= w_d;
      win_valid_q <= win_valid_d;
      win_sof_q <= win_sof_d;
      win_eol_q <= win_eol_d;
      win_eof_q <= win_eof_d;
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: table vectors plus randomized frames checked against a padded-window reference model
module tb_conv_window_gen;
  typedef logic [7:0] frame_t [3][4];
  typedef struct {
    logic [71:0] win;
    logic sof, eol, eof;
  } exp_t;
  typedef struct {
    int idx;
    logic [71:0] win;
    logic sof, eol, eof;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] pix_in = '0;
  logic pix_sof = 1'b0;
  logic pix_valid = 1'b0;
  logic pix_ready;
  logic [71:0] win;
  logic win_valid;
  logic win_ready = 1'b1;
  logic win_sof, win_eol, win_eof;
  int n_vec = 0;
  int n_err = 0;
  bit stall_en = 0;
  bit gap_en = 0;
  exp_t exp_q[$];
  logic [74:0] cap[$];
  logic held_v = 1'b0;
  logic [74:0] held_w = '0;
  frame_t pat, rnd;
  vec_t tbl[4];
  conv_window_gen #(.IMG_W(4), .IMG_H(3), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_sof(pix_sof), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .win(win), .win_valid(win_valid), .win_ready(win_ready),
    .win_sof(win_sof), .win_eol(win_eol), .win_eof(win_eof)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask
  task automatic push_frame(input frame_t f);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        exp_t e;
        e.win = '0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
            e.win = {e.win[63:0], (rr >= 0 && rr < 3 && cc >= 0 && cc < 4) ? f[rr][cc] : 8'd0};
          end
        e.sof = r == 0 && c == 0;
        e.eol = c == 3;
        e.eof = r == 2 && c == 3;
        exp_q.push_back(e);
      end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst) held_v = 1'b0;
    else begin
      if (held_v) chk("stall_hold", {4'd0, win_valid, win, win_sof, win_eol, win_eof}, {4'd0, 1'b1, held_w});
      if (win_valid && !win_ready) chk("ready_while_full", {79'd0, pix_ready}, 80'd0);
      if (win_valid && win_ready) begin
        cap.push_back({win, win_sof, win_eol, win_eof});
        if (exp_q.size() == 0) chk("unexpected_window", {5'd0, win, win_sof, win_eol, win_eof}, 80'd0);
        else begin
          e = exp_q.pop_front();
          chk("window", {5'd0, win, win_sof, win_eol, win_eof}, {5'd0, e.win, e.sof, e.eol, e.eof});
        end
      end
      held_v = win_valid && !win_ready;
      held_w = {win, win_sof, win_eol, win_eof};
    end
  end
  initial forever begin
    @(posedge clk);
    #1 win_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  task automatic drive_pix(input logic [7:0] p, input logic sof);
    pix_in = p;
    pix_sof = sof;
    pix_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (pix_ready) begin
        @(posedge clk);
        #1 pix_valid = 1'b0;
        return;
      end
    end
    pix_valid = 1'b0;
    chk("pix_accept_timeout", {79'd0, pix_ready}, 80'd1);
  endtask
  task automatic send_frame(input frame_t f, input int n, input bit flush);
    for (int i = 0; i < n; i++) begin
      drive_pix(f[i / 4][i % 4], i == 0);
      if (i == 0) begin
        if (flush) exp_q.delete();
        push_frame(f);
      end
      if (gap_en) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    chk("frame_windows_left", 80'(exp_q.size()), 80'd0);
    @(negedge clk);
    chk("idle_after_frame", {78'd0, win_valid, pix_ready}, 80'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) pat[r][c] = 8'(10 * r + c + 1);
    tbl[0] = '{0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd11, 8'd12}, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{7, {8'd3, 8'd4, 8'd0, 8'd13, 8'd14, 8'd0, 8'd23, 8'd24, 8'd0}, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{9, {8'd11, 8'd12, 8'd13, 8'd21, 8'd22, 8'd23, 8'd0, 8'd0, 8'd0}, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{11, {8'd13, 8'd14, 8'd0, 8'd23, 8'd24, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 1'b1, 1'b1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {79'd0, pix_ready}, 80'd0);
    chk("reset_outputs", {4'd0, win_valid, win, win_sof, win_eol, win_eof}, 80'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {79'd0, pix_ready}, 80'd1);
    cap.delete();
    send_frame(pat, 12, 1);
    wait_done();
    chk("window_count", 80'(cap.size()), 80'd12);
    for (int i = 0; i < 4; i++)
      chk("table_window", cap.size() > tbl[i].idx ? {5'd0, cap[tbl[i].idx]} : 80'hdead,
          {5'd0, tbl[i].win, tbl[i].sof, tbl[i].eol, tbl[i].eof});
    stall_en = 1;
    gap_en = 1;
    send_frame(pat, 12, 1);
    wait_done();
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 4; c++) rnd[r][c] = 8'($urandom);
      send_frame(rnd, 12, 1);
      wait_done();
    end
    stall_en = 0;
    gap_en = 0;
    send_frame(pat, 6, 1);
    send_frame(pat, 12, 1);
    wait_done();
    send_frame(pat, 12, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("ready_in_reset", {79'd0, pix_ready}, 80'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("valid_after_rst", {78'd0, win_valid, pix_ready}, 80'd1);
    for (int i = 0; i < 3; i++) drive_pix(8'hA5, 1'b0);
    repeat (4) @(negedge clk);
    chk("dropped_no_window", 80'(exp_q.size()), 80'd0);
    send_frame(pat, 12, 1);
    wait_done();
    send_frame(pat, 12, 0);
    send_frame(pat, 12, 0);
    wait_done();
    stall_en = 1;
    send_frame(pat, 12, 0);
    send_frame(rnd, 12, 0);
    wait_done();
    stall_en = 0;
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
